// File: rtl/controlador_de_partida.sv
// ---------------------------------------------------------------------------
// controlador_de_partida
//   Turn sequencer for one naval-battle match on the 5x7 LED board. Turns the
//   raw start/fire buttons into clean edges, validates the target coordinate,
//   drives the attack manager (enable / one-cycle confirmar strobe), counts
//   the remaining attempts and decides victory or defeat.
//
//   Optional feature macro: TEMPO_LIMITE_EN
//     defined   -> per-turn timer; a turn idle for TEMPO_LIMITE cycles costs
//                  an attempt and pulses tempo_esgotado
//     undefined -> no timer, tempo_esgotado tied low
//
// Ports
//   clock, reset                 system clock, synchronous active-high reset
//   botao_iniciar                raw start/restart button (asynchronous)
//   botao_confirmar              raw fire button (asynchronous)
//   coordColuna, coordLinha      target column (0..4) and row (0..6)
//   mapa0..mapa4                 ship map per column, bit n = row n
//   matriz0..matriz4             hit matrix reported by the attack manager
//   enable                       low clears the attack manager board
//   confirmar                    one-cycle attack strobe
//   tentativas                   attempts remaining
//   ultimo_acerto                last valid shot hit a fresh ship cell
//   coord_invalida               one-cycle pulse, out-of-range shot rejected
//   tempo_esgotado               one-cycle pulse, turn timed out
//   vitoria, derrota             match result, held until restart
// ---------------------------------------------------------------------------
module controlador_de_partida #(
  parameter int MAX_TENTATIVAS = 20,
  parameter int TEMPO_LIMITE   = 50_000_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       botao_iniciar,
  input  logic       botao_confirmar,
  input  logic [2:0] coordColuna,
  input  logic [2:0] coordLinha,
  input  logic [6:0] mapa0,
  input  logic [6:0] mapa1,
  input  logic [6:0] mapa2,
  input  logic [6:0] mapa3,
  input  logic [6:0] mapa4,
  input  logic [6:0] matriz0,
  input  logic [6:0] matriz1,
  input  logic [6:0] matriz2,
  input  logic [6:0] matriz3,
  input  logic [6:0] matriz4,
  output logic       enable,
  output logic       confirmar,
  output logic [4:0] tentativas,
  output logic       ultimo_acerto,
  output logic       coord_invalida,
  output logic       tempo_esgotado,
  output logic       vitoria,
  output logic       derrota
);

  typedef enum logic [2:0] {
    OCIOSO, REINICIO, JOGANDO, VALIDA, ATAQUE, AGUARDA, VITORIA, DERROTA
  } estado_t;

  estado_t    r_estado;
  logic [1:0] r_iniSync, r_cfmSync;
  logic       r_iniPrev, r_cfmPrev;
  logic       r_iniEdge, r_cfmEdge;
  logic [2:0] r_col, r_row;
  logic       r_enable, r_confirmar, r_ultimo, r_invalida, r_vitoria, r_derrota;
  logic [4:0] r_tent;

  logic [6:0] w_mapaSel, w_matrizSel;
  logic       w_alvoNovo, w_fora, w_vencido;

  // Two-flop synchronizer followed by a registered rising-edge detector, so
  // the FSM sees a button press three cycles after it is first sampled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_iniSync <= 2'b00;
      r_cfmSync <= 2'b00;
      r_iniPrev <= 1'b0;
      r_cfmPrev <= 1'b0;
      r_iniEdge <= 1'b0;
      r_cfmEdge <= 1'b0;
    end else begin
      r_iniSync <= {r_iniSync[0], botao_iniciar};
      r_cfmSync <= {r_cfmSync[0], botao_confirmar};
      r_iniPrev <= r_iniSync[1];
      r_cfmPrev <= r_cfmSync[1];
      r_iniEdge <= r_iniSync[1] & ~r_iniPrev;
      r_cfmEdge <= r_cfmSync[1] & ~r_cfmPrev;
    end
  end

  // Select the latched target column from map and hit matrix.
  always_comb begin
    w_mapaSel   = 7'd0;
    w_matrizSel = 7'd0;
    case (r_col)
      3'd0: begin w_mapaSel = mapa0; w_matrizSel = matriz0; end
      3'd1: begin w_mapaSel = mapa1; w_matrizSel = matriz1; end
      3'd2: begin w_mapaSel = mapa2; w_matrizSel = matriz2; end
      3'd3: begin w_mapaSel = mapa3; w_matrizSel = matriz3; end
      3'd4: begin w_mapaSel = mapa4; w_matrizSel = matriz4; end
      default: begin w_mapaSel = 7'd0; w_matrizSel = 7'd0; end
    endcase
  end

  assign w_fora     = (r_col > 3'd4) || (r_row > 3'd6);
  assign w_alvoNovo = w_mapaSel[r_row] & ~w_matrizSel[r_row];
  // An empty map must never count as sunk, otherwise it would win instantly.
  assign w_vencido  = (matriz0 == mapa0) && (matriz1 == mapa1) && (matriz2 == mapa2) &&
                      (matriz3 == mapa3) && (matriz4 == mapa4) &&
                      (|{mapa0, mapa1, mapa2, mapa3, mapa4});

`ifdef TEMPO_LIMITE_EN
  localparam int TW = (TEMPO_LIMITE > 1) ? $clog2(TEMPO_LIMITE) : 1;
  logic [TW-1:0] r_timer;
  logic          r_tempoEsg;
  logic          w_esgotou;

  assign w_esgotou = (r_timer == TW'(TEMPO_LIMITE - 1));

  // Turn timer runs only in JOGANDO; any other state holds it at zero, which
  // gives a fresh count on every entry to JOGANDO.
  always_ff @(posedge clock) begin
    if (reset || (r_estado != JOGANDO)) r_timer <= '0;
    else                                r_timer <= r_timer + 1'b1;
  end
`endif

  // Match sequencer. A start edge in any state except REINICIO restarts the
  // match and takes priority over a simultaneous fire edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_estado    <= OCIOSO;
      r_enable    <= 1'b0;
      r_confirmar <= 1'b0;
      r_tent      <= 5'd0;
      r_ultimo    <= 1'b0;
      r_invalida  <= 1'b0;
      r_vitoria   <= 1'b0;
      r_derrota   <= 1'b0;
      r_col       <= 3'd0;
      r_row       <= 3'd0;
`ifdef TEMPO_LIMITE_EN
      r_tempoEsg  <= 1'b0;
`endif
    end else begin
      r_confirmar <= 1'b0;
      r_invalida  <= 1'b0;
`ifdef TEMPO_LIMITE_EN
      r_tempoEsg  <= 1'b0;
`endif
      if (r_iniEdge && (r_estado != REINICIO)) begin
        r_estado  <= REINICIO;
        r_enable  <= 1'b0;
        r_tent    <= 5'(MAX_TENTATIVAS);
        r_ultimo  <= 1'b0;
        r_vitoria <= 1'b0;
        r_derrota <= 1'b0;
      end else begin
        case (r_estado)
          OCIOSO: r_estado <= OCIOSO;
          REINICIO: begin
            r_enable <= 1'b1;
            r_estado <= JOGANDO;
          end
          JOGANDO: begin
            if (r_cfmEdge) begin
              r_col    <= coordColuna;
              r_row    <= coordLinha;
              r_estado <= VALIDA;
            end
`ifdef TEMPO_LIMITE_EN
            else if (w_esgotou) begin
              r_tempoEsg <= 1'b1;
              r_ultimo   <= 1'b0;
              if (r_tent != 5'd0) r_tent <= r_tent - 5'd1;
              r_estado   <= AGUARDA;
            end
`endif
          end
          VALIDA: begin
            if (w_fora) begin
              r_invalida <= 1'b1;
              r_estado   <= JOGANDO;
            end else begin
              r_ultimo    <= w_alvoNovo;
              r_confirmar <= 1'b1;
              r_estado    <= ATAQUE;
            end
          end
          ATAQUE: begin
            if (r_tent != 5'd0) r_tent <= r_tent - 5'd1;
            r_estado <= AGUARDA;
          end
          AGUARDA: begin
            if (w_vencido) begin
              r_vitoria <= 1'b1;
              r_estado  <= VITORIA;
            end else if (r_tent == 5'd0) begin
              r_derrota <= 1'b1;
              r_estado  <= DERROTA;
            end else begin
              r_estado <= JOGANDO;
            end
          end
          VITORIA: r_estado <= VITORIA;
          DERROTA: r_estado <= DERROTA;
          default: r_estado <= OCIOSO;
        endcase
      end
    end
  end

  assign enable         = r_enable;
  assign confirmar      = r_confirmar;
  assign tentativas     = r_tent;
  assign ultimo_acerto  = r_ultimo;
  assign coord_invalida = r_invalida;
  assign vitoria        = r_vitoria;
  assign derrota        = r_derrota;
`ifdef TEMPO_LIMITE_EN
  assign tempo_esgotado = r_tempoEsg;
`else
  assign tempo_esgotado = 1'b0;
`endif

endmodule

// File: tb/tb_controlador_de_partida.sv
// ---------------------------------------------------------------------------
// tb_controlador_de_partida
//   Drives the match controller together with a small behavioural attack
//   manager and compares its outputs with a shot-level reference model.
// ---------------------------------------------------------------------------
module tb_controlador_de_partida;

  localparam int MAXT = 3;
  localparam int TLIM = 100;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       botao_iniciar = 1'b0;
  logic       botao_confirmar = 1'b0;
  logic [2:0] coordColuna = 3'd0;
  logic [2:0] coordLinha = 3'd0;
  logic [6:0] tbMapa [5];
  logic [6:0] amMatriz [5];
  logic       enable, confirmar, ultimo_acerto, coord_invalida, tempo_esgotado;
  logic       vitoria, derrota;
  logic [4:0] tentativas;

  int nCompared = 0;
  int nMismatch = 0;

  controlador_de_partida #(.MAX_TENTATIVAS(MAXT), .TEMPO_LIMITE(TLIM)) dut (
    .clock(clock), .reset(reset),
    .botao_iniciar(botao_iniciar), .botao_confirmar(botao_confirmar),
    .coordColuna(coordColuna), .coordLinha(coordLinha),
    .mapa0(tbMapa[0]), .mapa1(tbMapa[1]), .mapa2(tbMapa[2]), .mapa3(tbMapa[3]), .mapa4(tbMapa[4]),
    .matriz0(amMatriz[0]), .matriz1(amMatriz[1]), .matriz2(amMatriz[2]),
    .matriz3(amMatriz[3]), .matriz4(amMatriz[4]),
    .enable(enable), .confirmar(confirmar), .tentativas(tentativas),
    .ultimo_acerto(ultimo_acerto), .coord_invalida(coord_invalida),
    .tempo_esgotado(tempo_esgotado), .vitoria(vitoria), .derrota(derrota)
  );

  always #5 clock = ~clock;

  // Behavioural attack manager: clears while enable is low, marks a ship
  // cell as hit on every strobe aimed at it.
  always @(posedge clock) begin
    if (reset || !enable) begin
      for (int i = 0; i < 5; i++) amMatriz[i] <= 7'd0;
    end else if (confirmar && coordColuna < 3'd5 && coordLinha < 3'd7) begin
      amMatriz[coordColuna] <= amMatriz[coordColuna] | (tbMapa[coordColuna] & (7'd1 << coordLinha));
    end
  end

  // Pulse counters sampled just after each rising edge.
  int   cyc = 0, nConf = 0, nInv = 0, nTo = 0, nEnLow = 0, lastConfCyc = 0, firstWinCyc = 0;
  logic prevVit = 1'b0;
  always @(posedge clock) begin
    #1;
    cyc++;
    if (confirmar === 1'b1) begin nConf++; lastConfCyc = cyc; end
    if (coord_invalida === 1'b1) nInv++;
    if (tempo_esgotado === 1'b1) nTo++;
    if (enable === 1'b0) nEnLow++;
    if (vitoria === 1'b1 && prevVit !== 1'b1) firstWinCyc = cyc;
    prevVit = vitoria;
  end

  // Reference model at shot level: attempts, ship cells left, result.
  int mTent, mShips, mSunk;
  bit mUlt, mWin, mLose;
  bit mShot [5][7];

  task automatic modelStart();
    mTent = MAXT; mUlt = 0; mWin = 0; mLose = 0; mShips = 0; mSunk = 0;
    for (int c = 0; c < 5; c++)
      for (int r = 0; r < 7; r++) begin
        mShot[c][r] = 0;
        if (tbMapa[c][r]) mShips++;
      end
  endtask

  task automatic modelShot(input int c, input int r, output int eConf, output int eInv);
    eConf = 0; eInv = 0;
    if (mWin || mLose) return;
    if (c > 4 || r > 6) begin eInv = 1; return; end
    eConf = 1;
    mUlt = tbMapa[c][r] && !mShot[c][r];
    if (mUlt) mSunk++;
    mShot[c][r] = 1;
    if (mTent > 0) mTent--;
    if (mShips > 0 && mSunk == mShips) mWin = 1;
    else if (mTent == 0) mLose = 1;
  endtask

  task automatic applyStimulus(input bit ini, input bit cfm, input int c, input int r);
    @(negedge clock);
    coordColuna = 3'(c); coordLinha = 3'(r);
    botao_iniciar = ini; botao_confirmar = cfm;
    repeat (2) @(negedge clock);
    botao_iniciar = 1'b0; botao_confirmar = 1'b0;
    repeat (8) @(negedge clock);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int c = 0; c < 5; c++) tbMapa[c] = 7'd0;
    repeat (3) @(negedge clock);
    nCompared++; if ({enable, confirmar, ultimo_acerto, coord_invalida, tempo_esgotado, vitoria, derrota} !== 7'd0) begin
      nMismatch++; $display("[TB] FAIL reset_flags: got %b want 0000000",
        {enable, confirmar, ultimo_acerto, coord_invalida, tempo_esgotado, vitoria, derrota}); end
    nCompared++; if (tentativas !== 5'd0) begin
      nMismatch++; $display("[TB] FAIL reset_tent: got %0d want 0", tentativas); end
    reset = 1'b0;
    applyStimulus(0, 1, 0, 0);
    nCompared++; if (nConf !== 0 || enable !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL idle_fire: got conf=%0d en=%b want 0 0", nConf, enable); end
    applyStimulus(1, 0, 0, 0);
    modelStart();
    nCompared++; if (enable !== 1'b1) begin
      nMismatch++; $display("[TB] FAIL start_enable: got %b want 1", enable); end
    nCompared++; if (tentativas !== 5'(MAXT) || vitoria !== 1'b0 || derrota !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL start_state: got tent=%0d v=%b d=%b want 3 0 0", tentativas, vitoria, derrota); end
  endtask

  task automatic test_vitoria();
    int c0, l0, gap;
    tbMapa[0] = 7'b0000001;
    l0 = nEnLow;
    applyStimulus(1, 0, 0, 0);
    modelStart();
    nCompared++; if (nEnLow - l0 !== 1) begin
      nMismatch++; $display("[TB] FAIL restart_enable_low: got %0d cycles want 1", nEnLow - l0); end
    c0 = nConf;
    applyStimulus(0, 1, 0, 0);
    gap = firstWinCyc - lastConfCyc;
    nCompared++; if (nConf - c0 !== 1 || ultimo_acerto !== 1'b1 || tentativas !== 5'd2) begin
      nMismatch++; $display("[TB] FAIL win_shot: got conf=%0d ult=%b tent=%0d want 1 1 2", nConf - c0, ultimo_acerto, tentativas); end
    nCompared++; if (vitoria !== 1'b1 || derrota !== 1'b0 || enable !== 1'b1) begin
      nMismatch++; $display("[TB] FAIL win_flag: got v=%b d=%b en=%b want 1 0 1", vitoria, derrota, enable); end
    nCompared++; if (gap < 1 || gap > 2) begin
      nMismatch++; $display("[TB] FAIL win_latency: got %0d cycles want 1..2", gap); end
    c0 = nConf;
    applyStimulus(0, 1, 0, 0);
    nCompared++; if (nConf - c0 !== 0 || vitoria !== 1'b1) begin
      nMismatch++; $display("[TB] FAIL fire_after_win: got conf=%0d v=%b want 0 1", nConf - c0, vitoria); end
  endtask

  task automatic test_derrota();
    int c0, l0;
    tbMapa[0] = 7'b1110001;
    l0 = nEnLow;
    applyStimulus(1, 0, 0, 0);
    nCompared++; if (nEnLow - l0 !== 1 || vitoria !== 1'b0 || tentativas !== 5'd3) begin
      nMismatch++; $display("[TB] FAIL restart_from_win: got low=%0d v=%b tent=%0d want 1 0 3", nEnLow - l0, vitoria, tentativas); end
    for (int i = 0; i < 3; i++) begin
      c0 = nConf;
      applyStimulus(0, 1, 0, 1);
      nCompared++; if (nConf - c0 !== 1 || ultimo_acerto !== 1'b0 || tentativas !== 5'(2 - i)) begin
        nMismatch++; $display("[TB] FAIL miss_shot%0d: got conf=%0d ult=%b tent=%0d want 1 0 %0d",
          i, nConf - c0, ultimo_acerto, tentativas, 2 - i); end
      nCompared++; if (derrota !== (i == 2) || vitoria !== 1'b0) begin
        nMismatch++; $display("[TB] FAIL loss_flag%0d: got d=%b v=%b want %0d 0", i, derrota, vitoria, i == 2); end
    end
  endtask

  task automatic test_invalida();
    int c0, i0;
    applyStimulus(1, 0, 0, 0);
    c0 = nConf; i0 = nInv;
    applyStimulus(0, 1, 5, 2);
    nCompared++; if (nInv - i0 !== 1 || nConf - c0 !== 0 || tentativas !== 5'd3) begin
      nMismatch++; $display("[TB] FAIL invalid_col: got inv=%0d conf=%0d tent=%0d want 1 0 3", nInv - i0, nConf - c0, tentativas); end
    c0 = nConf; i0 = nInv;
    applyStimulus(0, 1, 4, 7);
    nCompared++; if (nInv - i0 !== 1 || nConf - c0 !== 0 || tentativas !== 5'd3) begin
      nMismatch++; $display("[TB] FAIL invalid_row: got inv=%0d conf=%0d tent=%0d want 1 0 3", nInv - i0, nConf - c0, tentativas); end
  endtask

  task automatic test_simultaneo();
    int c0, l0;
    applyStimulus(0, 1, 1, 3);
    nCompared++; if (tentativas !== 5'd2) begin
      nMismatch++; $display("[TB] FAIL pre_abort_tent: got %0d want 2", tentativas); end
    c0 = nConf; l0 = nEnLow;
    applyStimulus(1, 1, 0, 0);
    nCompared++; if (nConf - c0 !== 0 || tentativas !== 5'd3 || nEnLow - l0 !== 1) begin
      nMismatch++; $display("[TB] FAIL start_and_fire: got conf=%0d tent=%0d low=%0d want 0 3 1", nConf - c0, tentativas, nEnLow - l0); end
  endtask

  task automatic test_timeout();
    int c0, t0;
    applyStimulus(1, 0, 0, 0);
    c0 = nConf; t0 = nTo;
    repeat (TLIM + 10) @(negedge clock);
`ifdef TEMPO_LIMITE_EN
    nCompared++; if (nTo - t0 !== 1 || tentativas !== 5'd2 || nConf - c0 !== 0 || ultimo_acerto !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL timeout: got to=%0d tent=%0d conf=%0d ult=%b want 1 2 0 0", nTo - t0, tentativas, nConf - c0, ultimo_acerto); end
`else
    nCompared++; if (nTo - t0 !== 0 || tentativas !== 5'd3 || nConf - c0 !== 0) begin
      nMismatch++; $display("[TB] FAIL no_timeout: got to=%0d tent=%0d conf=%0d want 0 3 0", nTo - t0, tentativas, nConf - c0); end
`endif
  endtask

  task automatic test_random();
    int shipC[$], shipR[$];
    int c, r, k, eConf, eInv, c0, i0;
    for (int m = 0; m < 8; m++) begin
      shipC.delete(); shipR.delete();
      for (int col = 0; col < 5; col++) begin
        tbMapa[col] = ($urandom_range(0, 2) == 0) ? (7'd1 << $urandom_range(0, 6)) : 7'd0;
        for (int row = 0; row < 7; row++)
          if (tbMapa[col][row]) begin shipC.push_back(col); shipR.push_back(row); end
      end
      applyStimulus(1, 0, 0, 0);
      modelStart();
      for (int s = 0; s < 6; s++) begin
        if (shipC.size() > 0 && $urandom_range(0, 1) == 1) begin
          k = $urandom_range(0, shipC.size() - 1);
          c = shipC[k]; r = shipR[k];
        end else begin
          c = $urandom_range(0, 5); r = $urandom_range(0, 7);
        end
        modelShot(c, r, eConf, eInv);
        c0 = nConf; i0 = nInv;
        applyStimulus(0, 1, c, r);
        nCompared++; if (nConf - c0 !== eConf || nInv - i0 !== eInv) begin
          nMismatch++; $display("[TB] FAIL rnd_pulses m%0d s%0d (%0d,%0d): got conf=%0d inv=%0d want %0d %0d",
            m, s, c, r, nConf - c0, nInv - i0, eConf, eInv); end
        nCompared++; if (tentativas !== 5'(mTent) || ultimo_acerto !== mUlt || vitoria !== mWin || derrota !== mLose) begin
          nMismatch++; $display("[TB] FAIL rnd_state m%0d s%0d: got tent=%0d ult=%b v=%b d=%b want %0d %0d %0d %0d",
            m, s, tentativas, ultimo_acerto, vitoria, derrota, mTent, mUlt, mWin, mLose); end
      end
    end
  endtask

  task automatic test_reset_midmatch();
    int c0;
    tbMapa[2] = 7'b0000100;
    applyStimulus(1, 0, 0, 0);
    applyStimulus(0, 1, 2, 2);
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    nCompared++; if (enable !== 1'b0 || tentativas !== 5'd0 || ultimo_acerto !== 1'b0 || vitoria !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL midmatch_reset: got en=%b tent=%0d ult=%b v=%b want 0 0 0 0", enable, tentativas, ultimo_acerto, vitoria); end
    reset = 1'b0;
    c0 = nConf;
    applyStimulus(0, 1, 2, 2);
    nCompared++; if (nConf - c0 !== 0 || enable !== 1'b0) begin
      nMismatch++; $display("[TB] FAIL fire_after_reset: got conf=%0d en=%b want 0 0", nConf - c0, enable); end
  endtask

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_vitoria();
    test_derrota();
    test_invalida();
    test_simultaneo();
    test_timeout();
    test_random();
    test_reset_midmatch();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
